// File: rtl/wrap030_dram_pkg.sv
// Shared types, defaults and helpers for the wrap030 DRAM controller.
package wrap030_dram_pkg;

  localparam int DEF_BANKS          = 2;
  localparam int DEF_ROW_BITS       = 11;
  localparam int DEF_COL_BITS       = 11;
  localparam int DEF_RAS_CYC        = 1;
  localparam int DEF_CAS_WAIT       = 1;
  localparam int DEF_PRE_CYC        = 2;
  localparam int DEF_REF_HOLD       = 3;
  localparam int DEF_REF_INTERVAL   = 390;
  localparam int DEF_INIT_CYC       = 5000;
  localparam int DEF_INIT_REFRESHES = 8;
  localparam int DEF_OVERLAY_LIMIT  = 'h80000;

  // Encoding order is also the stateDebug value.
  typedef enum logic [3:0] {
    ST_INIT = 4'd0,
    ST_IREF = 4'd1,
    ST_IDLE = 4'd2,
    ST_ROW  = 4'd3,
    ST_COL  = 4'd4,
    ST_ACK  = 4'd5,
    ST_RFC  = 4'd6,
    ST_RFR  = 4'd7,
    ST_PRE  = 4'd8
  } state_e;

  function automatic logic [3:0] state_dbg(input state_e s);
    return s;
  endfunction

  // Active-high CAS mask in memCas_n bit order: lane k (k=0 is D31:24) maps
  // to bit 3-k. Reads strobe every lane; writes strobe A1A0 .. A1A0+size-1.
  function automatic logic [3:0] cas_lanes(input logic [1:0] a, input logic [1:0] siz,
                                           input logic rd);
    int lo;
    int hi;
    logic [3:0] m;
    lo = int'(a);
    hi = lo + ((siz == 2'b00) ? 4 : int'(siz));
    m  = '0;
    for (int k = 0; k < 4; k++)
      if (rd || (k >= lo && k < hi)) m[3-k] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wrap030_dram_refresh.sv
// Refresh interval timer plus a small saturating count of owed refreshes.
module wrap030_dram_refresh #(
  parameter int REF_INTERVAL = 390
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic dec_i,
  output logic req_o
);
  localparam int TW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0]    pend_q, pend_d;
  logic          wrap;

  assign wrap = (tmr_q == TW'(REF_INTERVAL - 1));

  // A wrap in the same cycle as a request already counts as owed, so the
  // controller refreshes before servicing that request.
  assign req_o = wrap | (pend_q != 2'd0);

  // Next timer value and owed-refresh count (saturates at 3, floors at 0).
  always_comb begin
    tmr_d  = wrap ? '0 : tmr_q + 1'b1;
    pend_d = pend_q;
    if (wrap && !dec_i)
      pend_d = (pend_q == 2'd3) ? 2'd3 : pend_q + 2'd1;
    else if (!wrap && dec_i && pend_q != 2'd0)
      pend_d = pend_q - 2'd1;
  end

  // Timer and pending registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmr_q  <= '0;
      pend_q <= '0;
    end else begin
      tmr_q  <= tmr_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/wrap030_dram_ctrl.sv
// 68030 bus to page-less DRAM controller: init, CAS-before-RAS refresh,
// single-beat accesses terminated with 32-bit DSACK.
module wrap030_dram_ctrl
  import wrap030_dram_pkg::*;
#(
  parameter int BANKS          = DEF_BANKS,
  parameter int ROW_BITS       = DEF_ROW_BITS,
  parameter int COL_BITS       = DEF_COL_BITS,
  parameter int RAS_CYC        = DEF_RAS_CYC,
  parameter int CAS_WAIT       = DEF_CAS_WAIT,
  parameter int PRE_CYC        = DEF_PRE_CYC,
  parameter int REF_HOLD       = DEF_REF_HOLD,
  parameter int REF_INTERVAL   = DEF_REF_INTERVAL,
  parameter int INIT_CYC       = DEF_INIT_CYC,
  parameter int INIT_REFRESHES = DEF_INIT_REFRESHES,
  parameter int OVERLAY_LIMIT  = DEF_OVERLAY_LIMIT,
  localparam int BANK_BITS     = $clog2(BANKS),
  localparam int ADDR_W        = 2 + COL_BITS + ROW_BITS + BANK_BITS,
  localparam int MA_W          = (ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS
) (
  input  logic              busClk,
  input  logic              busReset,
  input  logic              busAS_n,
  input  logic              busRW_n,
  input  logic              busAddr31,
  input  logic [1:0]        busFC,
  input  logic [1:0]        busSiz,
  input  logic [ADDR_W-1:0] busAddr,
  input  logic              romOverlay,
  output logic [MA_W-1:0]   memAddr,
  output logic [BANKS-1:0]  memRas_n,
  output logic [3:0]        memCas_n,
  output logic              memWe_n,
  output logic              memBufE_n,
  output logic [1:0]        busDsack_n,
  output logic              busDsackOe,
  output logic              initDone,
  output logic [3:0]        stateDebug
);
  localparam int BW = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int CW = $clog2(INIT_CYC + RAS_CYC + CAS_WAIT + PRE_CYC + REF_HOLD + 2);
  localparam int IW = $clog2(INIT_REFRESHES + 2);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       iref_q;
  logic                init_done_q;
  logic [ROW_BITS-1:0] row_q;
  logic [COL_BITS-1:0] col_q;
  logic [BW-1:0]       bank_q, bank_in;
  logic [3:0]          cas_q;
  logic                we_q;
  logic                claim, ref_req;

  generate
    if (BANK_BITS > 0) begin : g_bank
      assign bank_in = busAddr[ADDR_W-1 -: BW];
    end else begin : g_nobank
      assign bank_in = '0;
    end
  endgenerate

  // Reads below the overlay limit belong to the boot ROM while overlay is on.
  assign claim = !busAS_n && !busAddr31 && (busFC[0] ^ busFC[1]) &&
                 !(busRW_n && romOverlay && (busAddr < ADDR_W'(OVERLAY_LIMIT)));

  wrap030_dram_refresh #(.REF_INTERVAL(REF_INTERVAL)) u_refresh (
    .clk_i (busClk),
    .rst_i (busReset),
    .dec_i (state_q == ST_RFC),
    .req_o (ref_req)
  );

  // State register.
  always_ff @(posedge busClk) begin
    if (busReset) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  // Next-state logic; cnt_q counts cycles spent in the current state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (cnt_q == CW'(INIT_CYC - 1)) state_d = ST_IREF;
      ST_IREF: state_d = (iref_q == IW'(INIT_REFRESHES)) ? ST_IDLE : ST_RFC;
      ST_IDLE: begin
        if (ref_req)    state_d = ST_RFC;
        else if (claim) state_d = ST_ROW;
      end
      ST_ROW: begin
        if (busAS_n)                      state_d = ST_PRE;
        else if (cnt_q == CW'(RAS_CYC))   state_d = ST_COL;
      end
      ST_COL: begin
        if (busAS_n)                      state_d = ST_PRE;
        else if (cnt_q == CW'(CAS_WAIT))  state_d = ST_ACK;
      end
      ST_ACK:  if (busAS_n) state_d = ST_PRE;
      ST_RFC:  state_d = ST_RFR;
      ST_RFR:  if (cnt_q == CW'(REF_HOLD - 1)) state_d = ST_PRE;
      ST_PRE:  if (cnt_q == CW'(PRE_CYC - 1)) state_d = init_done_q ? ST_IDLE : ST_IREF;
      default: state_d = ST_INIT;
    endcase
  end

  // Cycle counter, init refresh count and the latched access fields.
  always_ff @(posedge busClk) begin
    if (busReset) begin
      cnt_q       <= '0;
      iref_q      <= '0;
      init_done_q <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      bank_q      <= '0;
      cas_q       <= '0;
      we_q        <= 1'b1;
    end else begin
      cnt_q <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
      if (state_q == ST_IREF && state_d == ST_RFC)  iref_q <= iref_q + 1'b1;
      if (state_q == ST_IREF && state_d == ST_IDLE) init_done_q <= 1'b1;
      if (state_q == ST_IDLE && state_d == ST_ROW) begin
        row_q  <= busAddr[COL_BITS+2 +: ROW_BITS];
        col_q  <= busAddr[COL_BITS+1:2];
        bank_q <= bank_in;
        cas_q  <= cas_lanes(busAddr[1:0], busSiz, busRW_n);
        we_q   <= busRW_n;
      end
    end
  end

  // DRAM strobes and bus termination decoded from the current state.
  always_comb begin
    memRas_n   = '1;
    memCas_n   = 4'hF;
    memWe_n    = 1'b1;
    memBufE_n  = 1'b1;
    memAddr    = '0;
    busDsack_n = 2'b11;
    busDsackOe = 1'b0;
    case (state_q)
      ST_ROW: begin
        memAddr   = MA_W'(row_q);
        memBufE_n = 1'b0;
        memWe_n   = we_q;
        if (cnt_q != '0) memRas_n[bank_q] = 1'b0;
      end
      ST_COL: begin
        memAddr          = MA_W'(col_q);
        memBufE_n        = 1'b0;
        memWe_n          = we_q;
        memRas_n[bank_q] = 1'b0;
        if (cnt_q != '0) memCas_n = ~cas_q;
      end
      ST_ACK: begin
        memAddr          = MA_W'(col_q);
        memBufE_n        = 1'b0;
        memWe_n          = we_q;
        memRas_n[bank_q] = 1'b0;
        memCas_n         = ~cas_q;
        busDsack_n       = 2'b00;
        busDsackOe       = 1'b1;
      end
      ST_RFC: memCas_n = 4'h0;
      ST_RFR: begin
        memCas_n = 4'h0;
        memRas_n = '0;
      end
      default: ;
    endcase
  end

  assign initDone   = init_done_q;
  assign stateDebug = state_dbg(state_q);

endmodule
